// File: rtl/regfile_dump.sv
// Walks register-file addresses 0..NREGS-1 and streams each value out over a
// valid/ready handshake, pulsing done_o once the last register is accepted.
module regfile_dump #(
    parameter int unsigned NREGS = 32,
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 5
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic          abort_i,
    output logic [AW-1:0] rs_o,
    input  logic [DW-1:0] rdata_i,
    output logic [DW-1:0] data_o,
    output logic [AW-1:0] addr_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic          busy_o,
    output logic          done_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRead = 2'd1;
    localparam logic [1:0] StSend = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    localparam logic [AW-1:0] LastIdx = AW'(NREGS - 1);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [DW-1:0] data_q, data_d;
    logic [AW-1:0] addr_q, addr_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        addr_d  = addr_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    idx_d   = '0;
                    state_d = StRead;
                end
            end
            StRead: begin
                if (abort_i) begin
                    idx_d   = '0;
                    state_d = StIdle;
                end else begin
                    data_d  = rdata_i;
                    addr_d  = idx_q;
                    state_d = StSend;
                end
            end
            StSend: begin
                // Abort wins over a transfer landing on the same edge.
                if (abort_i) begin
                    idx_d   = '0;
                    state_d = StIdle;
                end else if (ready_i) begin
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = StRead;
                    end
                end
            end
            StDone: begin
                idx_d   = '0;
                state_d = StIdle;
            end
            default: begin
                idx_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            idx_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
        end
    end

    // Status outputs decode straight from state so reset clears them at once.
    always_comb begin
        rs_o    = idx_q;
        data_o  = data_q;
        addr_o  = addr_q;
        valid_o = (state_q == StSend);
        busy_o  = (state_q == StRead) || (state_q == StSend);
        done_o  = (state_q == StDone);
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: full dump, back-pressure, abort,
// asynchronous reset mid-dump and start requests while busy.
module tb_regfile_dump;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [4:0]  rs;
    logic [31:0] rdata;
    logic [31:0] data;
    logic [4:0]  addr;
    logic        valid;
    logic        ready;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rdata = regs[rs];

    regfile_dump #(.NREGS(32), .DW(32), .AW(5)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start),
        .abort_i (abort),
        .rs_o    (rs),
        .rdata_i (rdata),
        .data_o  (data),
        .addr_o  (addr),
        .valid_o (valid),
        .ready_i (ready),
        .busy_o  (busy),
        .done_o  (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 1 (the cycle after the start-sampling edge).
    task automatic start_dump();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic seek_send(input logic [4:0] a, output bit found);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (valid === 1'b1 && addr === a) found = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({rs, data, addr, valid, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rs=%0d data=%h addr=%0d v=%b b=%b d=%b, want all 0",
                     rs, data, addr, valid, busy, done);
        end
    endtask

    task automatic test_full_dump();
        int beats = 0;
        int dones = 0;
        ready = 1'b1;
        start_dump();
        checks++;
        if (busy !== 1'b1 || valid !== 1'b0) begin
            errors++;
            $display("FAIL full_read_cycle1: got busy=%b valid=%b, want 1 0", busy, valid);
        end
        for (int cyc = 1; cyc <= 80; cyc++) begin
            if (valid === 1'b1) begin
                checks++;
                if (cyc != 2 * beats + 2 || addr !== 5'(beats) ||
                    data !== 32'hA500_0000 + 32'(beats)) begin
                    errors++;
                    $display("FAIL full_beat: cyc=%0d addr=%0d data=%h, want cyc=%0d addr=%0d data=%h",
                             cyc, addr, data, 2 * beats + 2, beats, 32'hA500_0000 + 32'(beats));
                end
                beats++;
            end
            if (done === 1'b1) begin
                checks++;
                if (cyc != 65) begin
                    errors++;
                    $display("FAIL full_done_cycle: got %0d, want 65", cyc);
                end
                dones++;
            end
            tick();
        end
        checks++;
        if (beats != 32 || dones != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL full_totals: beats=%0d dones=%0d busy=%b, want 32 1 0", beats, dones, busy);
        end
    endtask

    task automatic test_back_pressure();
        bit found;
        int nxt = 4;
        int dones = 0;
        ready = 1'b1;
        start_dump();
        seek_send(5'd3, found);
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL bp_reach_addr3: got not found, want found");
        end
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (valid !== 1'b1 || addr !== 5'd3 || data !== 32'hA500_0003) begin
                errors++;
                $display("FAIL bp_hold: v=%b addr=%0d data=%h, want 1 3 a5000003", valid, addr, data);
            end
        end
        ready = 1'b1;
        tick();
        checks++;
        if (valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_after_xfer: v=%b busy=%b, want 0 1", valid, busy);
        end
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (valid === 1'b1) begin
                checks++;
                if (addr !== 5'(nxt) || data !== 32'hA500_0000 + 32'(nxt)) begin
                    errors++;
                    $display("FAIL bp_beat: addr=%0d data=%h, want %0d %h",
                             addr, data, nxt, 32'hA500_0000 + 32'(nxt));
                end
                nxt++;
            end
            if (done === 1'b1) dones++;
            tick();
        end
        checks++;
        if (nxt != 32 || dones != 1) begin
            errors++;
            $display("FAIL bp_totals: next=%0d dones=%0d, want 32 1", nxt, dones);
        end
    endtask

    task automatic test_abort();
        bit found;
        int stray = 0;
        ready = 1'b1;
        start_dump();
        seek_send(5'd10, found);
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL abort_reach_addr10: got not found, want found");
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rs !== 5'd0) begin
            errors++;
            $display("FAIL abort_idle: v=%b busy=%b done=%b rs=%0d, want 0 0 0 0",
                     valid, busy, done, rs);
        end
        for (int i = 0; i < 10; i++) begin
            if (valid === 1'b1 || busy === 1'b1 || done === 1'b1) stray++;
            tick();
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL abort_quiet: got %0d active cycles, want 0", stray);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        int stray = 0;
        int nxt = 0;
        int dones = 0;
        ready = 1'b1;
        start_dump();
        seek_send(5'd7, found);
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rst_reach_addr7: got not found, want found");
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rs, data, addr, valid, busy, done} !== '0) begin
            errors++;
            $display("FAIL rst_async: rs=%0d data=%h addr=%0d v=%b b=%b d=%b, want all 0",
                     rs, data, addr, valid, busy, done);
        end
        #1 rst_n = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            if (valid === 1'b1 || busy === 1'b1 || done === 1'b1) stray++;
            tick();
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL rst_quiet: got %0d active cycles, want 0", stray);
        end
        start_dump();
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (valid === 1'b1) begin
                checks++;
                if (addr !== 5'(nxt) || data !== 32'hA500_0000 + 32'(nxt)) begin
                    errors++;
                    $display("FAIL rst_redump_beat: addr=%0d data=%h, want %0d %h",
                             addr, data, nxt, 32'hA500_0000 + 32'(nxt));
                end
                nxt++;
            end
            if (done === 1'b1) dones++;
            tick();
        end
        checks++;
        if (nxt != 32 || dones != 1) begin
            errors++;
            $display("FAIL rst_redump_totals: beats=%0d dones=%0d, want 32 1", nxt, dones);
        end
    endtask

    task automatic test_start_busy();
        int beats = 0;
        int dones = 0;
        int late_busy = 0;
        ready = 1'b1;
        start_dump();
        for (int cyc = 0; cyc < 90; cyc++) begin
            // Hold start high through READ, SEND and DONE, drop it in IDLE.
            start = busy | done;
            if (valid === 1'b1) beats++;
            if (done === 1'b1) dones++;
            if (dones > 0 && done !== 1'b1 && busy === 1'b1) late_busy++;
            tick();
        end
        start = 1'b0;
        checks++;
        if (beats != 32 || dones != 1 || late_busy != 0) begin
            errors++;
            $display("FAIL start_busy: beats=%0d dones=%0d late_busy=%0d, want 32 1 0",
                     beats, dones, late_busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'hA500_0000 + 32'(i);
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        ready = 1'b0;
        #12;
        test_reset();
        rst_n = 1'b1;
        tick();
        test_full_dump();
        test_back_pressure();
        test_abort();
        test_reset_mid();
        test_start_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_dump.md
REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 SHALL have parameter NREGS, default 32, number of registers dumped (addresses 0..NREGS-1).
REQ-002 SHALL have parameter DW, default 32, register data width.
REQ-003 SHALL have parameter AW, default 5, register address width; NREGS <= 2**AW.
REQ-004 SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start_i  input  1  request a full dump; sampled only in IDLE.
REQ-007 SHALL have port abort_i  input  1  cancel a dump in progress.
REQ-008 SHALL have port rs_o  output  AW  read address driven to the register-file read port.
REQ-009 SHALL have port rdata_i  input  DW  combinational read data returned for rs_o.
REQ-010 SHALL have port data_o  output  DW  captured register value being sent.
REQ-011 SHALL have port addr_o  output  AW  register index of data_o.
REQ-012 SHALL have port valid_o  output  1  data_o/addr_o hold a beat for the sink.
REQ-013 SHALL have port ready_i  input  1  sink accepts the beat.
REQ-014 SHALL have port busy_o  output  1  dump in progress.
REQ-015 SHALL have port done_o  output  1  one-cycle pulse on dump completion.

Function
REQ-016 SHALL implement an FSM with states IDLE, READ, SEND, DONE.
REQ-017 IDLE: on start_i=1 at a rising edge, the block SHALL set idx=0 and go to READ; otherwise it SHALL stay in IDLE.
REQ-018 rs_o SHALL equal idx in every state; idx SHALL be AW bits wide.
REQ-019 READ (one cycle): at the edge, the block SHALL set data_o<=rdata_i and addr_o<=idx, and go to SEND.
REQ-020 SEND: valid_o SHALL be 1; data_o and addr_o SHALL be held stable while valid_o=1 and ready_i=0.
REQ-021 A transfer SHALL occur when valid_o=1 and ready_i=1 at a rising edge; exactly one transfer per register.
REQ-022 After a transfer with idx<NREGS-1, the block SHALL set idx<=idx+1 and go to READ.
REQ-023 After a transfer with idx==NREGS-1, the block SHALL go to DONE; idx SHALL not wrap.
REQ-024 DONE (one cycle): done_o SHALL be 1; the block SHALL then return to IDLE with idx<=0.
REQ-025 valid_o SHALL be 1 only in SEND; busy_o SHALL be 1 only in READ and SEND; done_o SHALL be 1 only in DONE.
REQ-026 start_i SHALL be ignored in READ, SEND and DONE; no dump queuing.
REQ-027 abort_i=1 in READ or SEND SHALL force IDLE at the next edge, with idx<=0, valid_o=0 and no done_o pulse; abort_i SHALL have priority over a simultaneous transfer.
REQ-028 abort_i in IDLE or DONE SHALL have no effect; DONE still pulses done_o.
REQ-029 Latency with ready_i held at 1, counting the start-sampling edge as edge 0: valid_o for register i SHALL be high in cycle 2i+2, and done_o SHALL be high in cycle 2*NREGS+1.
REQ-030 Register values SHALL be passed unmodified, including register 0.

Reset
REQ-031 rst_ni=0 SHALL immediately, without waiting for a clock edge, force IDLE, idx=0, rs_o=0, data_o=0, addr_o=0, valid_o=0, busy_o=0 and done_o=0.
REQ-032 Reset asserted mid-dump SHALL discard the dump; after release the block SHALL wait for a new start_i and SHALL not pulse done_o.

Verification
REQ-033 Bench SHALL cover a full dump: regfile preloaded with reg[i]=32'hA5000000+i, ready_i=1, start_i pulse -> 32 beats with addr_o 0..31 and data_o 32'hA5000000..32'hA500001F in order, done_o in cycle 65, busy_o low after.
REQ-034 Bench SHALL cover back-pressure: ready_i=0 for 5 cycles while addr_o=3 -> valid_o stays 1, data_o/addr_o stay stable, no beat for addr 4 until after the transfer.
REQ-035 Bench SHALL cover abort: abort_i=1 together with ready_i=1 during SEND of addr_o=10 -> no transfer counted, IDLE next cycle, valid_o=0, busy_o=0, no done_o.
REQ-036 Bench SHALL cover reset mid-operation: rst_ni low asynchronously during SEND of addr 7 -> all outputs 0 before the next edge; after release a new start_i dumps from addr 0.
REQ-037 Bench SHALL cover start while busy: start_i pulses during READ, SEND and DONE -> exactly one dump of 32 beats and one done_o pulse.
